// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - raster-to-3x3 window generator with two line buffers
//
// Takes one unsigned pixel per cycle in raster order and presents a
// registered 3x3 neighbourhood for the downstream sharpening MAC. Every tap
// is zero-extended to PIX_W+1 bits, so the MAC can treat it as signed.
// The stall input is the MAC's own stall, which keeps this stage and the MAC
// frozen together.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high; wins over stall and in_valid
//   stall      in   freeze: nothing is accepted and no register changes
//   in_valid   in   in_pixel is valid this cycle
//   in_pixel   in   [PIX_W-1:0] unsigned pixel, raster order
//   win        out  [0:2][0:2][PIX_W:0] taps; row 0 = oldest line,
//                   col 2 = newest pixel; MSB (sign) is always 0
//   win_valid  out  win holds a complete in-image window
//   frame_done out  1-cycle pulse together with the last window of a frame
module window_gen_3x3 #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PIX_W = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall,
  input  logic                        in_valid,
  input  logic [PIX_W-1:0]            in_pixel,
  output logic [0:2][0:2][PIX_W:0]    win,
  output logic                        win_valid,
  output logic                        frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]               col_q, col_d;
  logic [RW-1:0]               row_q, row_d;
  logic [0:2][0:2][PIX_W:0]    win_q, win_d;
  logic                        win_valid_q, win_valid_d;
  logic                        frame_done_q, frame_done_d;

  // lb0 holds the previous line, lb1 the line before that, both indexed by
  // column. Never cleared: a location is always rewritten before any window
  // that depends on it can be flagged valid.
  logic [PIX_W-1:0]            lb0_q [IMG_W];
  logic [PIX_W-1:0]            lb1_q [IMG_W];

  logic                        accept;
  logic                        col_last;
  logic                        row_last;

  assign accept   = in_valid & ~stall;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    frame_done_d = frame_done_q;

    if (!stall) begin
      if (in_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_d[i][0] = win_q[i][1];
          win_d[i][1] = win_q[i][2];
        end
        // Line buffer reads see the value from before this cycle's write.
        win_d[0][2] = {1'b0, lb1_q[col_q]};
        win_d[1][2] = {1'b0, lb0_q[col_q]};
        win_d[2][2] = {1'b0, in_pixel};

        // Columns 0..1 of a new row still carry taps from the previous row;
        // requiring col>=2 keeps those windows unflagged.
        win_valid_d  = (row_q >= ROW_TWO) && (col_q >= COL_TWO);
        frame_done_d = row_last && col_last;

        if (col_last) begin
          col_d = '0;
          row_d = row_last ? '0 : row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end else begin
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= in_pixel;
    end
  end

  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - self-checking bench for window_gen_3x3 (4x4 frames)
module tb_window_gen_3x3;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int PW = 8;

  logic                     clk;
  logic                     reset;
  logic                     stall;
  logic                     in_valid;
  logic [PW-1:0]            in_pixel;
  logic [0:2][0:2][PW:0]    win;
  logic                     win_valid;
  logic                     frame_done;

  window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .win        (win),
    .win_valid  (win_valid),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int vcnt   = 0;
  int fcnt   = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame is an image array filled in raster order; a
  // valid window is simply the 3x3 block of that image ending at the newest
  // pixel.
  int  img [H][W];
  int  mrow, mcol;
  bit  exp_valid, exp_fd, chk_win;
  int  exp_win [3][3];

  always @(posedge clk) begin
    if (reset) begin
      mrow = 0; mcol = 0;
      exp_valid = 0; exp_fd = 0; chk_win = 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          exp_win[i][j] = 0;
    end else if (!stall && in_valid) begin
      img[mrow][mcol] = int'(in_pixel);
      exp_valid = (mrow >= 2) && (mcol >= 2);
      exp_fd    = (mrow == H - 1) && (mcol == W - 1);
      chk_win   = exp_valid;
      if (exp_valid)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            exp_win[i][j] = img[mrow - 2 + i][mcol - 2 + j];
      mcol++;
      if (mcol == W) begin
        mcol = 0;
        mrow = (mrow + 1) % H;
      end
    end else if (!stall) begin
      exp_valid = 0;
      exp_fd    = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("win_valid", 32'(win_valid), 32'(exp_valid));
      chk("frame_done", 32'(frame_done), 32'(exp_fd));
      if (chk_win)
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            chk($sformatf("model_tap[%0d][%0d]", i, j), 32'(win[i][j]), 32'(exp_win[i][j]));
      if (win_valid === 1'b1)  vcnt++;
      if (frame_done === 1'b1) fcnt++;
    end
  end

  task automatic step(input bit v, input logic [PW-1:0] p, input bit s);
    in_valid = v;
    in_pixel = p;
    stall    = s;
    @(negedge clk);
  endtask

  function automatic logic [PW-1:0] px(input int r, input int c);
    return PW'(16 * r + c);
  endfunction

  task automatic send(input int r, input int c);
    step(1'b1, px(r, c), 1'b0);
  endtask

  task automatic chk_row(input string name, input int i, input int a, input int b, input int c);
    chk({name, "_c0"}, 32'(win[i][0]), 32'(a));
    chk({name, "_c1"}, 32'(win[i][1]), 32'(b));
    chk({name, "_c2"}, 32'(win[i][2]), 32'(c));
  endtask

  task automatic chk_first_win(input string name);
    chk({name, "_valid"}, 32'(win_valid), 32'd1);
    chk_row({name, "_r0"}, 0, 0, 1, 2);
    chk_row({name, "_r1"}, 1, 16, 17, 18);
    chk_row({name, "_r2"}, 2, 32, 33, 34);
  endtask

  // Plain gap-free frame with literal checks on the first window.
  task automatic plain_frame(input string name);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c);
        if (r == 2 && c == 2) chk_first_win(name);
      end
  endtask

  initial begin
    int base_v, base_f, mac;
    reset = 1'b1; stall = 1'b0; in_valid = 1'b0; in_pixel = '0;
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'hAA, 1'b1);
    reset = 1'b0;
    started = 1'b1;
    chk("rst_valid", 32'(win_valid), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    chk("rst_win", 32'(win == '0), 32'd1);

    // 1: gap-free frame
    base_v = vcnt; base_f = fcnt;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c);
        if (r == 2 && c == 2) chk_first_win("t1_first");
        if (r == 2 && c == 3) chk_row("t1_p2_r2", 2, 33, 34, 35);
        if (r == 3 && c == 2) chk("t1_fd_p3", 32'(frame_done), 32'd0);
        if (r == 3 && c == 3) chk("t1_fd_p4", 32'(frame_done), 32'd1);
      end
    step(1'b0, '0, 1'b0);
    chk("t1_pulses", 32'(vcnt - base_v), 32'd4);
    chk("t1_fd_cnt", 32'(fcnt - base_f), 32'd1);

    // 2: three idle cycles after (2,1)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c);
        if (r == 2 && c == 1)
          for (int k = 0; k < 3; k++) begin
            step(1'b0, 8'h55, 1'b0);
            chk("t2_gap_valid", 32'(win_valid), 32'd0);
          end
        if (r == 2 && c == 2) chk_first_win("t2_first");
      end

    // 3: stall for 4 cycles with a valid window at (2,2)
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        send(r, c);
        if (r == 2 && c == 2) begin
          for (int k = 0; k < 4; k++) begin
            step(1'b1, px(2, 3), 1'b1);
            chk("t3_stall_valid", 32'(win_valid), 32'd1);
            chk_row("t3_stall_r2", 2, 32, 33, 34);
          end
        end
        if (r == 2 && c == 3) begin
          chk_row("t3_rel_r0", 0, 1, 2, 3);
          chk_row("t3_rel_r1", 1, 17, 18, 19);
          chk_row("t3_rel_r2", 2, 33, 34, 35);
        end
      end

    // 4: reset at (3,1), then a fresh frame
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c < 1) send(r, c);
    reset = 1'b1;
    send(3, 1);
    reset = 1'b0;
    chk("t4_rst_valid", 32'(win_valid), 32'd0);
    chk("t4_rst_fd", 32'(frame_done), 32'd0);
    chk("t4_rst_win", 32'(win == '0), 32'd1);
    step(1'b0, '0, 1'b0);
    base_v = vcnt; base_f = fcnt;
    plain_frame("t4_first");
    step(1'b0, '0, 1'b0);
    chk("t4_pulses", 32'(vcnt - base_v), 32'd4);
    chk("t4_fd_cnt", 32'(fcnt - base_f), 32'd1);

    // 5: all-255 frame, sharpened by the MAC kernel
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1'b1, 8'hFF, 1'b0);
        if (win_valid) begin
          chk("t5_tap00", 32'(win[0][0]), 32'h0FF);
          chk("t5_tap22", 32'(win[2][2]), 32'h0FF);
          mac = 5 * int'($signed(win[1][1])) - int'($signed(win[0][1]))
                - int'($signed(win[2][1])) - int'($signed(win[1][0]))
                - int'($signed(win[1][2]));
          chk("t5_mac", 32'(mac), 32'd255);
        end
      end

    // 6: two back-to-back frames
    step(1'b0, '0, 1'b0);
    base_v = vcnt; base_f = fcnt;
    plain_frame("t6_f1");
    plain_frame("t6_f2");
    step(1'b0, '0, 1'b0);
    chk("t6_pulses", 32'(vcnt - base_v), 32'd8);
    chk("t6_fd_cnt", 32'(fcnt - base_f), 32'd2);

    // Random valid/stall/pixels with an occasional reset; the model checks.
    for (int k = 0; k < 600; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      step(bit'($urandom_range(0, 3) != 0), PW'($urandom), bit'($urandom_range(0, 4) == 0));
      reset = 1'b0;
    end
    step(1'b0, '0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
